// File: rtl/router_fsm_nport_if.sv
// ----------------------------------------------------------------------------
// router_fsm_nport_if
//   Control/handshake bundle between the 1xN router FSM, the input register
//   block, the packet source and the N-way output FIFO bank.
//
//   Modports:
//     slave  : the FSM (consumes packet/FIFO status, drives state strobes)
//     master : the surrounding datapath/source (drives status, sees strobes)
//
//   Signals:
//     pkt_valid      packet byte valid from source
//     data_in        header address bits (meaningful in DECODE_ADDRESS)
//     parity_done    parity byte captured by the register block
//     low_pkt_valid  pkt_valid fell while the FIFO was full
//     fifo_full      full flag of the selected FIFO
//     fifo_empty     per-port FIFO empty flags
//     soft_reset     per-port soft reset (read-side timeout)
//     detect_add / lfd_state / ld_state / laf_state / full_state
//                    one-hot state strobes
//     write_enb_reg  FIFO write enable
//     rst_int_reg    high in CHECK_PARITY_ERROR
//     busy           source must hold data
//     addr_q         latched destination port
//     drop_pkt       one-cycle pulse: packet rejected
// ----------------------------------------------------------------------------
interface router_fsm_nport_if #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2
);
  logic                 pkt_valid;
  logic [ADDR_W-1:0]    data_in;
  logic                 parity_done;
  logic                 low_pkt_valid;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] soft_reset;

  logic                 detect_add;
  logic                 lfd_state;
  logic                 ld_state;
  logic                 laf_state;
  logic                 full_state;
  logic                 write_enb_reg;
  logic                 rst_int_reg;
  logic                 busy;
  logic [ADDR_W-1:0]    addr_q;
  logic                 drop_pkt;

  modport slave (
    input  pkt_valid, data_in, parity_done, low_pkt_valid,
           fifo_full, fifo_empty, soft_reset,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
           write_enb_reg, rst_int_reg, busy, addr_q, drop_pkt
  );

  modport master (
    output pkt_valid, data_in, parity_done, low_pkt_valid,
           fifo_full, fifo_empty, soft_reset,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
           write_enb_reg, rst_int_reg, busy, addr_q, drop_pkt
  );
endinterface

// File: rtl/router_fsm_nport.sv
// ----------------------------------------------------------------------------
// router_fsm_nport
//   Control FSM for a 1xN packet router. Decodes and latches the header
//   address, sequences header / payload / parity / full-stall handling and
//   drives load and write strobes to the register block and the FIFO bank.
//   Headers addressing a non-existent port are rejected with drop_pkt.
//   A soft reset of the currently selected port aborts the packet.
//
//   Parameters:
//     NUM_PORTS    number of output ports (2..16)
//     ADDR_W       header address width, 2**ADDR_W >= NUM_PORTS
//     WTE_TIMEOUT  cycles allowed in WAIT_TILL_EMPTY (timeout build only)
//
//   Ports:
//     clk     rising-edge clock
//     resetn  asynchronous active-low reset
//     bus     router_fsm_nport_if.slave (status in, strobes/addr_q/drop out)
//
//   Build option:
//     ROUTER_FSM_TIMEOUT_EN  when defined, a packet stuck in WAIT_TILL_EMPTY
//                            for WTE_TIMEOUT cycles is dropped. Otherwise the
//                            FSM waits indefinitely for the FIFO to drain.
// ----------------------------------------------------------------------------
module router_fsm_nport #(
  parameter int NUM_PORTS   = 3,
  parameter int ADDR_W      = 2,
  parameter int WTE_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               resetn,
  router_fsm_nport_if.slave  bus
);

  localparam int              PAD_W       = 1 << ADDR_W;
  localparam logic [ADDR_W:0] NUM_PORTS_W = (ADDR_W+1)'(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > 16 || PAD_W < NUM_PORTS || WTE_TIMEOUT < 1)
  begin : g_param_err
    $error("router_fsm_nport: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    ST_DA  = 3'b000,  // DECODE_ADDRESS
    ST_LFD = 3'b001,  // LOAD_FIRST_DATA
    ST_WTE = 3'b010,  // WAIT_TILL_EMPTY
    ST_LD  = 3'b011,  // LOAD_DATA
    ST_LP  = 3'b100,  // LOAD_PARITY
    ST_FFS = 3'b101,  // FIFO_FULL_STATE
    ST_CPE = 3'b110,  // CHECK_PARITY_ERROR
    ST_LAF = 3'b111   // LOAD_AFTER_FULL
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              drop_q,  drop_d;

  // Per-port flags widened to the full address space so any address value
  // indexes in range; ports beyond NUM_PORTS read as 0.
  logic [PAD_W-1:0]  empty_pad;
  logic [PAD_W-1:0]  sreset_pad;
  logic              addr_ok;
  logic              timeout;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    empty_pad                   = '0;
    sreset_pad                  = '0;
    empty_pad[NUM_PORTS-1:0]    = bus.fifo_empty;
    sreset_pad[NUM_PORTS-1:0]   = bus.soft_reset;
  end

  assign addr_ok = {1'b0, bus.data_in} < NUM_PORTS_W;

`ifdef ROUTER_FSM_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(WTE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WTE_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts cycles spent in WTE; outside WTE it sits at zero, so it is
  // already cleared on the cycle the FSM enters WTE.
  always_comb begin
    cnt_d = '0;
    if (state_q == ST_WTE) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign timeout = (state_q == ST_WTE) && (cnt_q == CNT_LAST);
`else
  assign timeout = 1'b0;
`endif

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_DA;
      addr_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drop_d  = 1'b0;

    case (state_q)
      ST_DA: begin
        if (bus.pkt_valid) begin
          if (addr_ok) begin
            addr_d  = bus.data_in;
            state_d = empty_pad[bus.data_in] ? ST_LFD : ST_WTE;
          end else begin
            drop_d  = 1'b1;
          end
        end
      end
      ST_WTE: begin
        // A drained FIFO on the timeout cycle still lets the packet through.
        if (empty_pad[addr_q]) begin
          state_d = ST_LFD;
        end else if (timeout) begin
          state_d = ST_DA;
          drop_d  = 1'b1;
        end
      end
      ST_LFD: state_d = ST_LD;
      ST_LD: begin
        if (bus.fifo_full)       state_d = ST_FFS;
        else if (!bus.pkt_valid) state_d = ST_LP;
      end
      ST_FFS: begin
        if (!bus.fifo_full) state_d = ST_LAF;
      end
      ST_LAF: begin
        if (bus.parity_done)        state_d = ST_DA;
        else if (bus.low_pkt_valid) state_d = ST_LP;
        else                        state_d = ST_LD;
      end
      ST_LP:  state_d = ST_CPE;
      ST_CPE: state_d = bus.fifo_full ? ST_FFS : ST_DA;
      default: state_d = ST_DA;
    endcase

    // Soft reset of the selected port aborts any packet in flight.
    if (state_q != ST_DA && sreset_pad[addr_q]) begin
      state_d = ST_DA;
      drop_d  = 1'b0;
    end
  end

  // Moore output decode
  logic detect_add, lfd_state, ld_state, laf_state, full_state;
  logic write_enb_reg, rst_int_reg, busy;

  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b0;
    case (state_q)
      ST_DA:  detect_add = 1'b1;
      ST_LFD: begin lfd_state = 1'b1; busy = 1'b1; end
      ST_WTE: busy = 1'b1;
      ST_LD:  begin ld_state = 1'b1; write_enb_reg = 1'b1; end
      ST_LP:  begin write_enb_reg = 1'b1; busy = 1'b1; end
      ST_FFS: begin full_state = 1'b1; busy = 1'b1; end
      ST_CPE: begin rst_int_reg = 1'b1; busy = 1'b1; end
      ST_LAF: begin laf_state = 1'b1; write_enb_reg = 1'b1; busy = 1'b1; end
      default: detect_add = 1'b1;
    endcase
  end

  assign bus.detect_add    = detect_add;
  assign bus.lfd_state     = lfd_state;
  assign bus.ld_state      = ld_state;
  assign bus.laf_state     = laf_state;
  assign bus.full_state    = full_state;
  assign bus.write_enb_reg = write_enb_reg;
  assign bus.rst_int_reg   = rst_int_reg;
  assign bus.busy          = busy;
  assign bus.addr_q        = addr_q;
  assign bus.drop_pkt      = drop_q;

endmodule
